// File: rtl/ones_count_ctrl.sv
// ones_count_ctrl: round-robin arbiter in front of one shared CHUNK-bit
// popcount slice. A granted W-bit word is counted over W/CHUNK cycles.
// The result comes back on ones/done_id with a one-cycle done pulse.
// Optional feature macro: EARLY_EXIT_EN. When it is defined, a word finishes
// as soon as the bits still waiting to be counted are all zero.
module ones_count_ctrl #(
  parameter int NREQ  = 4,
  parameter int W     = 16,
  parameter int CHUNK = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*W-1:0]         data,
  output logic [NREQ-1:0]           grant,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(NREQ)-1:0]   done_id,
  output logic [$clog2(W+1)-1:0]    ones
);

  localparam int IDW = $clog2(NREQ);
  localparam int OW  = $clog2(W+1);
  localparam int NCH = W / CHUNK;
  localparam int CIW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state_reg, state_next;
  logic [W-1:0]     shift_reg, shift_next;
  logic [OW-1:0]    acc_reg, acc_next;
  logic [CIW-1:0]   cidx_reg, cidx_next;
  logic [IDW-1:0]   id_reg, id_next;
  logic [IDW-1:0]   last_reg, last_next;
  logic [NREQ-1:0]  grant_reg, grant_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [OW-1:0]    ones_reg, ones_next;
  logic [IDW-1:0]   done_id_reg, done_id_next;

  // Arbitration signals.
  logic [NREQ-1:0]  rot_req;
  logic [IDW-1:0]   win_off;
  logic [IDW-1:0]   win;
  logic [NREQ-1:0]  win_onehot;
  logic             any_req;

  // Counting signals.
  logic [OW-1:0]    chunk_pc;
  logic [OW-1:0]    sum;
  logic             last_chunk;
  logic             finish;

  // Rotate the request vector so bit 0 is the requester after the last winner.
  // The one-hot grant is decoded from the winner index.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    logic [IDW-1:0] src;
    assign src            = last_reg + IDW'(gi + 1);
    assign rot_req[gi]    = req[src];
    assign win_onehot[gi] = (win == IDW'(gi));
  end

  // Lowest set bit of the rotated vector is the round-robin winner.
  always_comb begin
    win_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot_req[i]) win_off = IDW'(i);
    end
  end

  assign win     = last_reg + IDW'(1) + win_off;
  assign any_req = |req;

  // Popcount of the chunk currently at the bottom of the shift register.
  always_comb begin
    chunk_pc = '0;
    for (int i = 0; i < CHUNK; i++) begin
      chunk_pc = chunk_pc + OW'(shift_reg[i]);
    end
  end

  // The sum is at most W, which fits in OW bits, so it cannot overflow.
  assign sum        = acc_reg + chunk_pc;
  assign last_chunk = (cidx_reg == CIW'(NCH - 1));

`ifdef EARLY_EXIT_EN
  // Finish early once nothing nonzero remains above the chunk being counted.
  assign finish = last_chunk | ((shift_reg >> CHUNK) == '0);
`else
  assign finish = last_chunk;
`endif

  // Next-state and output logic: IDLE arbitrates and captures, COUNT accumulates.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    acc_next     = acc_reg;
    cidx_next    = cidx_reg;
    id_next      = id_reg;
    last_next    = last_reg;
    grant_next   = '0;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    ones_next    = ones_reg;
    done_id_next = done_id_reg;
    unique case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = COUNT;
          shift_next = data[win*W +: W];
          acc_next   = '0;
          cidx_next  = '0;
          id_next    = win;
          last_next  = win;
          grant_next = win_onehot;
          busy_next  = 1'b1;
        end
      end
      COUNT: begin
        shift_next = shift_reg >> CHUNK;
        acc_next   = sum;
        cidx_next  = cidx_reg + CIW'(1);
        if (finish) begin
          ones_next    = sum;
          done_id_next = id_reg;
          done_next    = 1'b1;
          busy_next    = 1'b0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register. Reset aborts any word in flight and rewinds the pointer
  // so that requester 0 has first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      acc_reg     <= '0;
      cidx_reg    <= '0;
      id_reg      <= '0;
      last_reg    <= IDW'(NREQ - 1);
      grant_reg   <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      ones_reg    <= '0;
      done_id_reg <= '0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      acc_reg     <= acc_next;
      cidx_reg    <= cidx_next;
      id_reg      <= id_next;
      last_reg    <= last_next;
      grant_reg   <= grant_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      ones_reg    <= ones_next;
      done_id_reg <= done_id_next;
    end
  end

  assign grant   = grant_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign done_id = done_id_reg;
  assign ones    = ones_reg;

endmodule
